// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the single-cycle MIPS datapath: register-file
// geometry, architecturally special register numbers, and the ALUctr
// encoding shared by the ALU and the control unit.
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;   // $zero, hard-wired
  localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;  // $ra, link register

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     data_t;

  // Storage for $1..$31 only; $0 is never stored.
  typedef data_t [NUM_REGS-1:1] reg_array_t;

  // ALUctr encoding.
  typedef enum logic [3:0] {
    ADD  = 4'b1110,
    SUB  = 4'b0100,
    AND  = 4'b0010,
    OR   = 4'b0011,
    XOR  = 4'b0111,
    SLL  = 4'b1010,
    SRL  = 4'b1000,
    SRA  = 4'b1001,
    ADDU = 4'b0001,
    BEQ  = 4'b0101,
    LUI  = 4'b0110,
    JR   = 4'b1100
  } alu_ctr_e;

endpackage : cpu_pkg

// File: rtl/reg_file_rdport.sv
// -----------------------------------------------------------------------------
// reg_file_rdport
// One combinational read port of the register file: returns zero for $0,
// otherwise the stored value, optionally replaced by the write data when a
// qualified write targets the same register in the same cycle.
//
// Ports:
//   regs   in  31x32  current contents of $1..$31
//   ra     in  5      read address
//   wr_en  in  1      qualified write this cycle (out of reset, we=1, wa!=0)
//   wa     in  5      write address
//   wd     in  32     write data
//   rd     out 32     read data
// -----------------------------------------------------------------------------
module reg_file_rdport
  import cpu_pkg::*;
#(
  parameter bit BYPASS = 1'b0
) (
  input  reg_array_t            regs,
  input  logic [REG_ADDR_W-1:0] ra,
  input  logic                  wr_en,
  input  logic [REG_ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0]     wd,
  output logic [DATA_W-1:0]     rd
);

  always_comb begin
    // NOTE: rd gets a value on every path (default first) so no latch is inferred.
    rd = '0;
    if (ra == REG_ZERO) begin
      rd = '0;
    end else if (BYPASS && wr_en && (wa == ra)) begin
      // wr_en already excludes wa==0 and reset, so this never exposes $0.
      rd = wd;
    end else begin
      rd = regs[ra];
    end
  end

endmodule : reg_file_rdport

// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file
// 32 x 32-bit MIPS general-purpose register file. Two combinational read
// ports feed the ALU operand paths, one synchronous write port takes the
// writeback value, and a debug port shows the stored contents (never bypassed).
// $0 reads as zero and ignores writes.
//
// Parameters:
//   WRITE_BYPASS  forward same-cycle write data to rd1/rd2 when 1
//   RESET_VALUE   value of $1..$31 after reset
//
// Ports:
//   clk       in  1   rising-edge clock
//   rst_n     in  1   asynchronous active-low reset
//   we        in  1   write enable
//   wa        in  5   write address
//   wd        in  32  write data
//   ra1, ra2  in  5   read addresses (rs, rt)
//   rd1, rd2  out 32  read data
//   dbg_addr  in  5   debug read address
//   dbg_data  out 32  debug read data (stored value only)
// -----------------------------------------------------------------------------
module reg_file
  import cpu_pkg::*;
#(
  parameter bit          WRITE_BYPASS = 1'b0,
  parameter logic [31:0] RESET_VALUE  = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0]     wd,
  input  logic [REG_ADDR_W-1:0] ra1,
  input  logic [REG_ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0]     rd1,
  output logic [DATA_W-1:0]     rd2,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0]     dbg_data
);

  reg_array_t regs;
  logic       wr_en;

  // Including rst_n keeps the bypass suppressed while reset is asserted.
  assign wr_en = rst_n && we && (wa != REG_ZERO);

  // NOTE: every register here is reset because the architecture promises a
  // known value in $1..$31; this is a flop array, not an SRAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs[i] <= RESET_VALUE;
      end
    end else if (we && (wa != REG_ZERO)) begin
      // NOTE: non-blocking so the same-edge readers all see the pre-edge value.
      regs[wa] <= wd;
    end
  end

  reg_file_rdport #(.BYPASS(WRITE_BYPASS)) u_rdport1 (
    .regs  (regs),
    .ra    (ra1),
    .wr_en (wr_en),
    .wa    (wa),
    .wd    (wd),
    .rd    (rd1)
  );

  reg_file_rdport #(.BYPASS(WRITE_BYPASS)) u_rdport2 (
    .regs  (regs),
    .ra    (ra2),
    .wr_en (wr_en),
    .wa    (wa),
    .wd    (wd),
    .rd    (rd2)
  );

  reg_file_rdport #(.BYPASS(1'b0)) u_rdport_dbg (
    .regs  (regs),
    .ra    (dbg_addr),
    .wr_en (wr_en),
    .wa    (wa),
    .wd    (wd),
    .rd    (dbg_data)
  );

endmodule : reg_file

// File: tb/tb_reg_file.sv
// -----------------------------------------------------------------------------
// tb_reg_file
// Drives two register files from the same stimulus: one with default
// parameters, one with bypass enabled and a non-zero reset value. Each is
// compared against a plain array model of the architectural registers.
// -----------------------------------------------------------------------------
module tb_reg_file;

  localparam logic [31:0] RV_BYP = 32'h0BAD_F00D;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [4:0]  ra1, ra2, dbg_addr;
  logic [31:0] rd1_a, rd2_a, dbg_a;
  logic [31:0] rd1_b, rd2_b, dbg_b;

  int checks = 0;
  int errors = 0;

  // Architectural model: index 0 unused (reads of $0 return 0).
  logic [31:0] m_a [32];
  logic [31:0] m_b [32];

  always #5 clk = ~clk;

  reg_file u_dut_a (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_a), .rd2(rd2_a),
    .dbg_addr(dbg_addr), .dbg_data(dbg_a)
  );

  reg_file #(.WRITE_BYPASS(1'b1), .RESET_VALUE(RV_BYP)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
    .dbg_addr(dbg_addr), .dbg_data(dbg_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_a[i] = 32'h0;
      m_b[i] = RV_BYP;
    end
  endtask

  // Expected read value for instance b (bypass) or a; dbg reads pass byp=0.
  function automatic logic [31:0] mread(input bit inst_b, input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'h0;
    if (inst_b && byp && rst_n && we && (wa != 5'd0) && (wa == a)) return wd;
    return inst_b ? m_b[a] : m_a[a];
  endfunction

  task automatic check_reads(input string tag);
    check({tag, "/a_rd1"}, rd1_a, mread(1'b0, ra1, 1'b0));
    check({tag, "/a_rd2"}, rd2_a, mread(1'b0, ra2, 1'b0));
    check({tag, "/a_dbg"}, dbg_a, mread(1'b0, dbg_addr, 1'b0));
    check({tag, "/b_rd1"}, rd1_b, mread(1'b1, ra1, 1'b1));
    check({tag, "/b_rd2"}, rd2_b, mread(1'b1, ra2, 1'b1));
    check({tag, "/b_dbg"}, dbg_b, mread(1'b1, dbg_addr, 1'b0));
  endtask

  // Apply inputs at the falling edge; an asserted reset clears the model at once.
  task automatic drive(input logic r, input logic w, input logic [4:0] a,
                       input logic [31:0] d, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [4:0] dbg);
    @(negedge clk);
    rst_n = r; we = w; wa = a; wd = d; ra1 = r1; ra2 = r2; dbg_addr = dbg;
    if (!r) model_reset();
  endtask

  // Rising edge, then settle; the model commits what the edge should commit.
  task automatic edge_update();
    @(posedge clk);
    if (rst_n && we && (wa != 5'd0)) begin
      m_a[wa] = wd;
      m_b[wa] = wd;
    end
    #1;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    drive(1'b1, 1'b1, a, d, a, a, a);
    edge_update();
    check_reads("wr_post");
  endtask

  initial begin
    rst_n = 1'b1; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0; dbg_addr = '0;
    model_reset();

    // 1. Reset with a write presented: the write must be lost.
    drive(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd0, 5'd5);
    #1 check_reads("rst_hold");
    edge_update();
    edge_update();
    check("rst_hold_a_r5", dbg_a, 32'h0);
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      check("rst_sweep_a", dbg_a, 32'h0);
      check("rst_sweep_b", dbg_b, (i == 0) ? 32'h0 : RV_BYP);
    end

    // 2. Operand writes feeding an ALU add.
    write_reg(5'd1, 32'h34);
    write_reg(5'd2, 32'h12);
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2, 5'd1);
    #1;
    check("op_rd1", rd1_a, 32'h0000_0034);
    check("op_rd2", rd2_a, 32'h0000_0012);
    check("op_sum", rd1_a + rd2_a, 32'h46);
    check_reads("op");

    // 3. $0 is not writable.
    drive(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
    edge_update();
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    #1;
    check("zero_a_rd1", rd1_a, 32'h0);
    check("zero_a_rd2", rd2_a, 32'h0);
    check("zero_b_rd1", rd1_b, 32'h0);
    check("zero_b_dbg", dbg_b, 32'h0);

    // 4. Same-cycle write and read of $3.
    write_reg(5'd3, 32'h1234);
    drive(1'b1, 1'b1, 5'd3, 32'hAAAA, 5'd3, 5'd4, 5'd3);
    #1;
    check("same_pre_a_rd1", rd1_a, 32'h1234);
    check("same_pre_b_rd1", rd1_b, 32'hAAAA);
    check("same_pre_b_dbg", dbg_b, 32'h1234);
    check_reads("same_pre");
    edge_update();
    check("same_post_a_rd1", rd1_a, 32'hAAAA);
    check("same_post_b_dbg", dbg_b, 32'hAAAA);

    // 5. Asynchronous reset between edges, with a write presented.
    write_reg(5'd31, 32'hFFFF_FFF8);
    drive(1'b1, 1'b1, 5'd31, 32'h5555_0000, 5'd31, 5'd31, 5'd31);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_a_dbg31", dbg_a, 32'h0);
    check("async_b_dbg31", dbg_b, RV_BYP);
    check("async_b_nobyp", rd1_b, RV_BYP);
    check_reads("async");
    edge_update();
    check("async_edge_a_dbg31", dbg_a, 32'h0);
    check_reads("async_edge");
    // Release before the next edge: the first write after release lands.
    drive(1'b1, 1'b1, 5'd9, 32'h0000_9999, 5'd9, 5'd31, 5'd9);
    edge_update();
    check("release_a_dbg9", dbg_a, 32'h0000_9999);
    check_reads("release");

    // 6. Both ports on one register, then a full write/readback sweep.
    write_reg(5'd7, 32'h1FFF_FFFF);
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 5'd7);
    #1;
    check("dual_rd1", rd1_a, 32'h1FFF_FFFF);
    check("dual_rd2", rd2_a, 32'h1FFF_FFFF);
    check("dual_b_eq", rd1_b, rd2_b);
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 1'b1, 5'(i), 32'(i) * 32'h0101_0101, 5'(i), 5'(i), 5'(i));
      edge_update();
    end
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 5'(i));
      #1;
      check("sweep_rd1", rd1_a, 32'(i) * 32'h0101_0101);
      check("sweep_rd2", rd2_a, 32'(31 - i) * 32'h0101_0101);
      check_reads("sweep");
    end

    // 7. Random traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] a, r1, r2;
      a  = 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 3) == 0) ? r1 : 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 39) != 0), 1'($urandom), a, $urandom,
            r1, r2, 5'($urandom_range(0, 31)));
      #1 check_reads("rand_pre");
      edge_update();
      check_reads("rand_post");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_reg_file

// File: doc/reg_file.md
# reg_file

General-purpose register file for the single-cycle MIPS datapath. It sits directly upstream of the ALU and supplies operands A and B. It holds 32 × 32-bit registers, with two asynchronous read ports and one synchronous write port. The write port takes the writeback value (ALU Result or load data). Register $0 is hard-wired to zero, and a debug read port exposes any register to the bench.

## Interface
Parameters:
- WRITE_BYPASS, default 0: when 1, a same-cycle write to a register being read is forwarded to that read port.
- RESET_VALUE, default 32'h0000_0000: value loaded into $1..$31 on reset.

Ports:
- clk — in — 1 — single clock; all state updates on the rising edge.
- rst_n — in — 1 — reset, asynchronous and active-low.
- we — in — 1 — write enable for the write port.
- wa — in — 5 — write address.
- wd — in — 32 — write data from the writeback mux.
- ra1 — in — 5 — read address, port 1 (rs; drives ALU A path).
- ra2 — in — 5 — read address, port 2 (rt; drives ALU B path).
- rd1 — out — 32 — read data, port 1.
- rd2 — out — 32 — read data, port 2.
- dbg_addr — in — 5 — debug read address.
- dbg_data — out — 32 — debug read data; never bypassed.

## Operation
- Storage: registers $1..$31 are flops. $0 has no storage, and any read of address 0 returns 0.
- Write: at the rising clk edge with rst_n=1 and we=1 and wa≠0, reg[wa] takes wd.
  - A write with wa=0 is silently discarded.
  - we=0 leaves all registers unchanged.
- Read: rd1, rd2 and dbg_data are purely combinational from the current register contents and address.
- Bypass, only when WRITE_BYPASS=1: rdN = wd if all of the following hold:
  - rst_n=1
  - we=1
  - wa≠0
  - wa==raN
  
  Otherwise rdN = reg[raN]. dbg_data always shows the stored value.
- Both read ports addressing the same register return identical data.
- Reset: rst_n=0 asynchronously forces $1..$31 to RESET_VALUE, independent of clk.
  - While rst_n=0, writes are ignored and bypass is suppressed.
  - Outputs during reset: rd1, rd2 and dbg_data = RESET_VALUE, or 0 for address 0.
- Reset asserted mid-write: reset wins, and the register holds RESET_VALUE.
- Reset release: the first write takes effect at the first rising edge that sees rst_n=1 with setup met.
- No arithmetic is performed; widths are fixed at 5-bit addresses and 32-bit data.

## Timing
- Write latency: 1 edge. The data is visible on the read ports immediately after the edge that writes it.
- Read latency: 0 cycles (combinational). The path ra→rd must fit within the single-cycle budget ahead of the ALU.
- Write and read of the same register in the same cycle:
  - WRITE_BYPASS=0: the read returns the old value until the edge, then the new value.
  - WRITE_BYPASS=1: the read returns wd within the same cycle.
- No handshake. we is sampled only at the clock edge, and glitches between edges have no effect.
- Reset assertion affects outputs combinationally, without waiting for clk.

## Structure
- Shared package cpu_pkg holds:
  - REG_ADDR_W=5 and DATA_W=32
  - REG_ZERO=5'd0 and REG_RA=5'd31
  - the ALUctr encoding constants used by the ALU and control: ADD=4'b1110, SUB=4'b0100, AND=4'b0010, OR=4'b0011, XOR=4'b0111, SLL=4'b1010, SRL=4'b1000, SRA=4'b1001, ADDU=4'b0001, BEQ=4'b0101, LUI=4'b0110, JR=4'b1100
- One sub-module, reg_file_rdport, implements the zero check, the read mux and the optional bypass.
  - It is instantiated for rd1 and rd2 with bypass enabled per WRITE_BYPASS.
  - It is instantiated for dbg_data with bypass disabled.

## Test plan
1. Reset: hold rst_n=0 and pulse clk with we=1, wa=5, wd=32'hDEAD_BEEF → after release, dbg_data for every address 0..31 equals 0.
2. Operand write: write $1=32'h34 and $2=32'h12, then set ra1=1 and ra2=2 → rd1=32'h0000_0034, rd2=32'h0000_0012. These values feed the ALU add case, which must produce 32'h46.
3. $0 protection: write wa=0 with wd=32'hFFFF_FFFF, then read ra1=0 and ra2=0 → both read 0.
4. Same-cycle read/write: ra1=3 with we=1, wa=3, wd=32'hAAAA, where $3 was previously 32'h1234.
   - WRITE_BYPASS=0: rd1=32'h1234 before the edge and 32'hAAAA after it.
   - WRITE_BYPASS=1: rd1=32'hAAAA before the edge, while dbg_data (dbg_addr=3) still reads 32'h1234.
5. Async reset mid-run: with $31=32'hFFFF_FFF8, drop rst_n between clock edges → dbg_data for address 31 goes to 0 without any clk edge, and a write presented in the same cycle is lost.
6. Dual-port same address: ra1=ra2=7 after $7=32'h1FFF_FFFF → rd1=rd2=32'h1FFF_FFFF. Then sweep writes to all 31 registers with value = address × 32'h0101_0101 and read them back through both ports.
